fetch_npc_unit: RTL

// - Instruction-fetch and next-PC stage of the SCPU; sits upstream of ctrl_unit.
// - Owns the PC register and performs a req/ack fetch from instruction memory.
// - Holds the fetched word in an instruction register (IR) that feeds the decoder.
// - Takes NPCOp back from ctrl_unit, resolves the branch/jump target and commits it.
// - Controls sequencing: a commit strobe for RF/DM writes, halt on NPC_NOP, fault flags.

---
 rtl/fetch_npc_unit_pkg.sv | 28 ++
 rtl/fetch_npc_unit_if.sv | 9 +
 rtl/fetch_npc_unit_npc_calc.sv | 20 ++
 rtl/fetch_npc_unit.sv | 77 +++++++
 4 files changed

// File: rtl/fetch_npc_unit_pkg.sv
// fetch_npc_unit_pkg: NPC op codes, FSM states, fault codes and branch-condition helper
package fetch_npc_unit_pkg;
  localparam logic [3:0] NPC_PLUS4 = 4'd0;
  localparam logic [3:0] NPC_BEQ   = 4'd1;
  localparam logic [3:0] NPC_BNE   = 4'd2;
  localparam logic [3:0] NPC_BGTZ  = 4'd3;
  localparam logic [3:0] NPC_BLEZ  = 4'd4;
  localparam logic [3:0] NPC_BLTZ  = 4'd5;
  localparam logic [3:0] NPC_BGEZ  = 4'd6;
  localparam logic [3:0] NPC_JUMP  = 4'd7;
  localparam logic [3:0] NPC_JUMPR = 4'd8;
  localparam logic [3:0] NPC_NOP   = 4'd15;
  localparam logic [1:0] FLT_NONE  = 2'b00;
  localparam logic [1:0] FLT_ALIGN = 2'b01;
  localparam logic [1:0] FLT_TMO   = 2'b10;
  typedef enum logic [1:0] {FS_FETCH = 2'd0, FS_EXEC = 2'd1, FS_HALT = 2'd2} fstate_t;
  function automatic logic branch_taken(input logic [3:0] op, input logic [31:0] rs, input logic zero);
    logic pos, neg;
    neg = rs[31];
    pos = !rs[31] && (|rs);
    return op == NPC_BEQ  ? zero :
           op == NPC_BNE  ? !zero :
           op == NPC_BGTZ ? pos :
           op == NPC_BLEZ ? !pos :
           op == NPC_BLTZ ? neg :
           op == NPC_BGEZ ? !neg : 1'b0;
  endfunction
endpackage

// File: rtl/fetch_npc_unit_if.sv
// fetch_npc_unit_if: instruction-memory req/ack fetch bus
interface fetch_npc_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;
  modport master (output req, addr, input ack, rdata);
  modport slave (input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_npc_unit_npc_calc.sv
// npc_calc: combinational next-PC target from pc, IR, NPCOp and branch conditions
module npc_calc
  import fetch_npc_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] ir,
  input  logic [3:0]  npc_op,
  input  logic [31:0] rs_data,
  input  logic        alu_zero,
  output logic [31:0] target
);
  logic [31:0] p4, off;
  always_comb begin
    p4 = pc + 32'd4;
    off = {{14{ir[15]}}, ir[15:0], 2'b00};
    target = npc_op == NPC_JUMP  ? {p4[31:28], ir, 2'b00} :
             npc_op == NPC_JUMPR ? rs_data :
             branch_taken(npc_op, rs_data, alu_zero) ? p4 + off : p4;
  end
endmodule

// File: rtl/fetch_npc_unit.sv
// fetch_npc_unit: PC/IR ownership, req/ack instruction fetch, next-PC commit, halt and fault sequencing
module fetch_npc_unit
  import fetch_npc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  fetch_npc_unit_if.master  im,
  output logic [31:0]       instr,
  input  logic [3:0]        npc_op,
  input  logic [31:0]       rs_data,
  input  logic              alu_zero,
  input  logic              stall,
  output logic              commit,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic              halted,
  output logic [1:0]        fault
);
  localparam int CW = $clog2(TIMEOUT + 1);
  fstate_t     state;
  logic [CW-1:0] cnt;
  logic [31:0] target;
  logic        go;
  npc_calc u_calc (
    .pc       (pc),
    .ir       (instr[25:0]),
    .npc_op   (npc_op),
    .rs_data  (rs_data),
    .alu_zero (alu_zero),
    .target   (target)
  );
  assign pc_plus4 = pc + 32'd4;
  assign im.req   = state == FS_FETCH;
  assign im.addr  = pc;
  assign halted   = state == FS_HALT;
  assign go       = state == FS_EXEC && !stall && npc_op != NPC_NOP;
  assign commit   = go && target[1:0] == 2'b00;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FS_FETCH;
      pc    <= RESET_PC;
      instr <= '0;
      cnt   <= '0;
      fault <= FLT_NONE;
    end else begin
      case (state)
        FS_FETCH:
          if (im.ack) begin
            instr <= im.rdata;
            cnt   <= '0;
            state <= FS_EXEC;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            fault <= FLT_TMO;
            state <= FS_HALT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        FS_EXEC:
          if (!stall) begin
            if (npc_op == NPC_NOP) begin
              state <= FS_HALT;
            end else if (target[1:0] != 2'b00) begin
              fault <= FLT_ALIGN;
              state <= FS_HALT;
            end else begin
              pc    <= target;
              state <= FS_FETCH;
            end
          end
        default: ;
      endcase
    end
  end
endmodule
